fetch_icache_unit: RTL and testbench

//  Instruction-fetch front end: a 32-bit halfword program counter (index) plus a

---
 rtl/fetch_icache_unit.sv | 81 ++++++++
 tb/tb_fetch_icache_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_icache_unit.sv
// Instruction-fetch front end: a halfword fetch counter that steps by 1 + delta_i,
// plus a synchronous single-read / single-write instruction store read at the counter.
module fetch_icache_unit #(
    parameter logic [31:0] RESET_INDEX = 32'd10,
    parameter int          DEPTH       = 256
) (
    input  logic        clk,
    input  logic        not_reset,
    input  logic [31:0] delta_i,
    input  logic        not_enable,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic [31:0] index,
    output logic [15:0] data,
    output logic        data_valid
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [15:0]   mem_r [DEPTH];
    logic [31:0]   index_r;
    logic [15:0]   data_r;
    logic          data_valid_r;

    logic [31:0]   index_next_s;
    logic [15:0]   data_next_s;
    logic          data_valid_next_s;
    logic          rd_in_range_s;
    logic          wr_in_range_s;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] wr_addr_s;

    assign rd_in_range_s = (index_r < DEPTH_W);
    assign wr_in_range_s = (ld_addr < DEPTH_W);
    assign rd_addr_s     = index_r[AW-1:0];
    assign wr_addr_s     = ld_addr[AW-1:0];

    // Next fetch index and next read result, both taken from the pre-update index.
    always_comb begin
        index_next_s      = index_r + 32'd1 + delta_i;
        data_next_s       = 16'h0000;
        data_valid_next_s = 1'b0;
        if (!not_enable) begin
            data_valid_next_s = 1'b1;
            if (rd_in_range_s) begin
                data_next_s = mem_r[rd_addr_s];
            end else begin
                data_next_s = 16'h0000;
            end
        end else begin
            data_valid_next_s = 1'b0;
        end
    end

    // Fetch counter and registered read port; reset does not touch the store.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            index_r      <= RESET_INDEX;
            data_r       <= 16'h0000;
            data_valid_r <= 1'b0;
        end else begin
            index_r      <= index_next_s;
            data_r       <= data_next_s;
            data_valid_r <= data_valid_next_s;
        end
    end

    // Load-port write; the read above sees the old word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (ld_en && wr_in_range_s) begin
            mem_r[wr_addr_s] <= ld_data;
        end
    end

    assign index      = index_r;
    assign data       = data_r;
    assign data_valid = data_valid_r;

endmodule

// File: tb/tb_fetch_icache_unit.sv
// Directed bench for fetch_icache_unit: a reference model predicts each edge's
// outputs into a scoreboard queue, which is popped and compared after the edge.
module tb_fetch_icache_unit;

    typedef struct {
        logic [31:0] idx;
        logic [15:0] data;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        not_reset;
    logic [31:0] delta_i;
    logic        not_enable;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [15:0] ld_data;
    logic [31:0] index;
    logic [15:0] data;
    logic        data_valid;

    int checks   = 0;
    int failures = 0;

    exp_t        sb_q[$];
    logic [31:0] m_idx;
    logic [15:0] m_mem [256];

    fetch_icache_unit #(.RESET_INDEX(32'd10), .DEPTH(256)) dut (
        .clk        (clk),
        .not_reset  (not_reset),
        .delta_i    (delta_i),
        .not_enable (not_enable),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .index      (index),
        .data       (data),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic [31:0] d, input logic ne, input logic le,
                        input logic [31:0] la, input logic [15:0] ldv, input string tag);
        exp_t e;
        exp_t got;
        delta_i    = d;
        not_enable = ne;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ldv;
        e.idx = m_idx + 32'd1 + d;
        if (!ne) begin
            e.valid = 1'b1;
            e.data  = (m_idx < 32'd256) ? m_mem[m_idx[7:0]] : 16'h0000;
        end else begin
            e.valid = 1'b0;
            e.data  = 16'h0000;
        end
        sb_q.push_back(e);
        if (le && la < 32'd256) m_mem[la[7:0]] = ldv;
        m_idx = e.idx;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({tag, "_index"}, index, got.idx);
            check({tag, "_data"}, {16'h0000, data}, {16'h0000, got.data});
            check({tag, "_valid"}, {31'd0, data_valid}, {31'd0, got.valid});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_index"}, index, 32'd10);
        check({tag, "_data"}, {16'h0000, data}, 32'd0);
        check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        not_reset  = 1'b0;
        delta_i    = 32'd0;
        not_enable = 1'b1;
        ld_en      = 1'b0;
        ld_addr    = 32'd0;
        ld_data    = 16'h0000;
        m_idx      = 32'd10;

        #12;
        check_reset_outputs("reset");
        #1 not_reset = 1'b1;
        step(32'd0, 1'b1, 1'b0, 32'd0, 16'h0000, "release");

        // Program load while holding the counter.
        step(32'hFFFF_FFFF, 1'b1, 1'b1, 32'd10, 16'hA5A5, "load10");
        step(32'hFFFF_FFFF, 1'b1, 1'b1, 32'd11, 16'h1234, "load11");
        step(32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 16'h0F0F, "load0");

        #2 not_reset = 1'b0;
        #1 check_reset_outputs("reset2");
        m_idx = 32'd10;
        #1 not_reset = 1'b1;

        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "seq1");
        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "seq2");
        step(32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, 16'h0000, "back1");
        step(32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, 16'h0000, "back2");
        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "after_back");

        for (int i = 0; i < 3; i++) step(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 16'h0000, "hold");

        // Jump to DEPTH, read out of range, and drop an out-of-range write.
        step(32'd244, 1'b0, 1'b0, 32'd0, 16'h0000, "to_depth");
        step(32'd0, 1'b0, 1'b1, 32'd256, 16'hDEAD, "oob_read");
        step(32'hFFFF_FEFE, 1'b0, 1'b0, 32'd0, 16'h0000, "to_zero");
        step(32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 16'hBEEF, "rw_same");
        step(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 16'h0000, "rw_next");

        step(32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, 16'h0000, "to_max");
        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "wrap");
        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "pre_async");

        // Reset asserted between edges must act without a clock edge.
        #2 not_reset = 1'b0;
        #1 check_reset_outputs("async");
        m_idx = 32'd10;
        #1 not_reset = 1'b1;
        step(32'd0, 1'b0, 1'b0, 32'd0, 16'h0000, "post_async");

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
